countdown_timer: RTL and testbench
==================================

# countdown_timer

Four-digit BCD countdown timer (MM:SS) for the digital clock design. It decrements toward 00:00 on each one-cycle seconds tick produced by the divider chain, so it is the counting-down counterpart of the up-counting divide/carry stages. It propagates borrow across digits, runs a small run/pause/done state machine, and drives an alarm output for a programmable number of ticks at expiry.

## Interface
- ALARM_LEN, default 4: number of TICK pulses ALARM stays high after expiry; range 1..15.
- CLK  in  1  system clock; all state updates on the falling edge.
- CLEAR  in  1  asynchronous, active-low reset.
- TICK  in  1  one-CLK-wide 1 Hz enable pulse from the divider chain.
- LOAD  in  1  load LD_* digits, level-sampled.
- START  in  1  start or resume counting, level-sampled.
- STOP  in  1  pause while running; acknowledge while done.
- LD_MIN_T, LD_MIN_U, LD_SEC_T, LD_SEC_U  in  4 each  BCD load value.
- MIN_T, MIN_U, SEC_T, SEC_U  out  4 each  current BCD count.
- RUNNING  out  1  high in RUN.
- DONE  out  1  high in DONE.
- ALARM  out  1  expiry alarm.

## Operation
- States: IDLE, RUN, PAUSE, DONE. CLEAR low forces the following immediately, including mid-count: IDLE, all digits 0, RUNNING=0, DONE=0, ALARM=0, alarm counter 0.
- Load clamping: each LD digit above 9 loads as 9. LD_SEC_T above 5 loads as 5.
- IDLE:
  - LOAD loads the digits.
  - Otherwise START with a nonzero count goes to RUN.
  - START with count 00:00 is ignored.
- RUN:
  - LOAD is ignored.
  - STOP goes to PAUSE, with no decrement even if TICK is high in the same cycle.
  - Otherwise TICK decrements by one second.
  - If the value before the decrement is 00:01, the count becomes 00:00 and the state becomes DONE on the same edge.
- PAUSE:
  - LOAD loads the digits and stays in PAUSE.
  - START with a nonzero count goes to RUN.
  - TICK is ignored.
- DONE:
  - ALARM is high on entry and counts TICKs; it falls on the edge of the ALARM_LEN-th TICK.
  - LOAD loads the digits and goes to IDLE.
  - STOP goes to IDLE, with the count left at 00:00.
  - Both outcomes clear ALARM.
- Priority within a cycle: LOAD > STOP > START > TICK.
- Decrement with borrow:
  - SEC_U 0 becomes 9 and borrows; otherwise SEC_U decrements.
  - On borrow, SEC_T 0 becomes 5 and borrows; otherwise SEC_T decrements.
  - On borrow, MIN_U 0 becomes 9 and borrows; otherwise MIN_U decrements.
  - On borrow, MIN_T decrements.
  - 00:00 is never decremented, so no underflow can occur.
- Digits only ever hold legal BCD values (SEC_T 0..5, all others 0..9).

## Timing
- All inputs are sampled on the falling edge of CLK. Outputs are registered and change only on that edge or on CLEAR.
- Latency:
  - TICK to digit update: same edge.
  - START to RUNNING: same edge.
  - Final TICK to DONE/ALARM high: same edge.
- The first decrement after START happens on the next TICK, not on the START edge.
- TICK is assumed one cycle wide; a wider pulse decrements once per cycle it is high.
- DONE and ALARM are never high outside DONE; RUNNING and DONE are mutually exclusive.

## Configuration
- COUNTDOWN_AUTORELOAD_EN defined:
  - The last loaded value is held in a shadow register.
  - On reaching 00:00 in RUN, the digits reload from the shadow register, the state stays RUN, DONE pulses high for one CLK cycle, and ALARM is not used (held 0).
  - STOP still pauses.
- Not defined: behaviour exactly as in Operation; no shadow register exists.

## Test plan
- CLEAR low mid-run at 12:34 -> all digits 0, IDLE, all outputs 0 immediately, without waiting for a CLK edge.
- LOAD 00:03, START, 3 TICKs -> 00:02, 00:01, 00:00; DONE=1 and ALARM=1 on the 3rd TICK edge; ALARM falls after 4 further TICKs; STOP -> IDLE.
- LOAD 10:00, START, 1 TICK -> 09:59 (full borrow chain).
- RUN at 05:00 with STOP and TICK in the same cycle -> PAUSE, count stays 05:00; LOAD in RUN ignored; START resumes.
- LOAD digits F,C,7,A -> clamps to 99:59; START with 00:00 loaded -> stays IDLE.
- With COUNTDOWN_AUTORELOAD_EN: LOAD 00:02, START, 2 TICKs -> DONE one-cycle pulse, count 00:02, RUNNING stays 1.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Control, load and display signals of the MM:SS countdown timer.
// The master drives controls and load digits; the slave (the timer) drives the count and flags.
interface countdown_timer_if;
   logic       tick;
   logic       load;
   logic       start;
   logic       stop;
   logic [3:0] ld_min_t;
   logic [3:0] ld_min_u;
   logic [3:0] ld_sec_t;
   logic [3:0] ld_sec_u;
   logic [3:0] min_t;
   logic [3:0] min_u;
   logic [3:0] sec_t;
   logic [3:0] sec_u;
   logic       running;
   logic       done;
   logic       alarm;

   modport master (
      output tick, load, start, stop, ld_min_t, ld_min_u, ld_sec_t, ld_sec_u,
      input  min_t, min_u, sec_t, sec_u, running, done, alarm
   );

   modport slave (
      input  tick, load, start, stop, ld_min_t, ld_min_u, ld_sec_t, ld_sec_u,
      output min_t, min_u, sec_t, sec_u, running, done, alarm
   );
endinterface

// File: rtl/countdown_timer.sv
// Four-digit BCD MM:SS countdown timer with run/pause/done control and an expiry alarm.
// Optional COUNTDOWN_AUTORELOAD_EN: reload from the last loaded value at 00:00 and keep running.
module countdown_timer #(
   parameter int ALARM_LEN = 4
) (
   input  logic               clk,
   input  logic               clear,
   countdown_timer_if.slave   bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;
   typedef logic [3:0][3:0] bcd_t;   // [3]=min_t [2]=min_u [1]=sec_t [0]=sec_u

   state_t     state, state_nxt;
   bcd_t       cnt, cnt_nxt, ld_val;
   logic       alarm_q, alarm_nxt;
   logic       done_q, done_nxt;
   logic       pulse_nxt;
   logic       ld_hit;
   logic [3:0] acnt, acnt_nxt, acnt_inc;
   logic       cnt_zero, cnt_one;

   function automatic logic [3:0] sat(input logic [3:0] d, input logic [3:0] lim);
      return (d > lim) ? lim : d;
   endfunction

   // Single-second decrement with borrow; never called on 00:00.
   function automatic bcd_t dec(input bcd_t c);
      bcd_t r;
      r = c;
      if (c[0] != 4'd0) r[0] = c[0] - 4'd1;
      else begin
         r[0] = 4'd9;
         if (c[1] != 4'd0) r[1] = c[1] - 4'd1;
         else begin
            r[1] = 4'd5;
            if (c[2] != 4'd0) r[2] = c[2] - 4'd1;
            else begin
               r[2] = 4'd9;
               r[3] = c[3] - 4'd1;
            end
         end
      end
      return r;
   endfunction

   assign ld_val   = {sat(bus.ld_min_t, 4'd9), sat(bus.ld_min_u, 4'd9),
                      sat(bus.ld_sec_t, 4'd5), sat(bus.ld_sec_u, 4'd9)};
   assign cnt_zero = (cnt == bcd_t'(16'h0000));
   assign cnt_one  = (cnt == bcd_t'(16'h0001));
   assign acnt_inc = acnt + 4'd1;

`ifdef COUNTDOWN_AUTORELOAD_EN
   bcd_t shadow;

   always_ff @(negedge clk or negedge clear) begin
      if (!clear)      shadow <= '0;
      else if (ld_hit) shadow <= ld_val;
   end
`endif

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      alarm_nxt = alarm_q;
      acnt_nxt  = acnt;
      pulse_nxt = 1'b0;
      ld_hit    = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.load) begin
               ld_hit  = 1'b1;
               cnt_nxt = ld_val;
            end else if (bus.start && !cnt_zero) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (bus.stop) begin
               state_nxt = S_PAUSE;
            end else if (bus.tick && !cnt_zero) begin
               if (cnt_one) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
                  cnt_nxt   = shadow;
                  pulse_nxt = 1'b1;
`else
                  cnt_nxt   = '0;
                  state_nxt = S_DONE;
                  alarm_nxt = 1'b1;
                  acnt_nxt  = 4'd0;
`endif
               end else begin
                  cnt_nxt = dec(cnt);
               end
            end
         end
         S_PAUSE: begin
            if (bus.load) begin
               ld_hit  = 1'b1;
               cnt_nxt = ld_val;
            end else if (bus.start && !cnt_zero) begin
               state_nxt = S_RUN;
            end
         end
         S_DONE: begin
            if (bus.load) begin
               ld_hit    = 1'b1;
               cnt_nxt   = ld_val;
               state_nxt = S_IDLE;
               alarm_nxt = 1'b0;
            end else if (bus.stop) begin
               state_nxt = S_IDLE;
               alarm_nxt = 1'b0;
            end else if (bus.tick && alarm_q) begin
               acnt_nxt = acnt_inc;
               if (acnt_inc == ALARM_LEN[3:0]) alarm_nxt = 1'b0;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      done_nxt = (state_nxt == S_DONE) | pulse_nxt;
   end

   always_ff @(negedge clk or negedge clear) begin
      if (!clear) begin
         state   <= S_IDLE;
         cnt     <= '0;
         alarm_q <= 1'b0;
         done_q  <= 1'b0;
         acnt    <= 4'd0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         alarm_q <= alarm_nxt;
         done_q  <= done_nxt;
         acnt    <= acnt_nxt;
      end
   end

   assign bus.min_t   = cnt[3];
   assign bus.min_u   = cnt[2];
   assign bus.sec_t   = cnt[1];
   assign bus.sec_u   = cnt[0];
   assign bus.running = (state == S_RUN);
   assign bus.done    = done_q;
   assign bus.alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios then random controls against a seconds-based model.
// Honours COUNTDOWN_AUTORELOAD_EN the same way the design does.
module tb_countdown_timer;
   localparam int ALEN = 4;

   logic clk = 1'b0;
   logic clear;
   int   checks = 0;
   int   errors = 0;

   countdown_timer_if bus ();
   countdown_timer #(.ALARM_LEN(ALEN)) dut (.clk(clk), .clear(clear), .bus(bus));

   always #5 clk = ~clk;

   // model: state 0 idle, 1 run, 2 pause, 3 done; count kept as total seconds
   int m_st, m_secs, m_shadow, m_acnt;
   bit m_alarm, m_pulse;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int s);
      int m, x;
      m = s / 60;
      x = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
   endfunction

   function automatic int ld_secs(input int a, input int b, input int c, input int d);
      if (a > 9) a = 9;
      if (b > 9) b = 9;
      if (c > 5) c = 5;
      if (d > 9) d = 9;
      return (a * 10 + b) * 60 + c * 10 + d;
   endfunction

   function automatic logic [15:0] dut_cnt();
      return {bus.min_t, bus.min_u, bus.sec_t, bus.sec_u};
   endfunction

   task automatic m_reset();
      m_st = 0; m_secs = 0; m_shadow = 0; m_acnt = 0; m_alarm = 0; m_pulse = 0;
   endtask

   task automatic m_step(input bit ld, input bit st, input bit sp, input bit tk, input int lv);
      m_pulse = 0;
      case (m_st)
         0: if (ld) begin m_secs = lv; m_shadow = lv; end
            else if (st && m_secs != 0) m_st = 1;
         1: if (sp) m_st = 2;
            else if (tk && m_secs > 0) begin
               m_secs--;
               if (m_secs == 0) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
                  m_secs = m_shadow; m_pulse = 1;
`else
                  m_st = 3; m_alarm = 1; m_acnt = 0;
`endif
               end
            end
         2: if (ld) begin m_secs = lv; m_shadow = lv; end
            else if (st && m_secs != 0) m_st = 1;
         default: if (ld) begin m_secs = lv; m_shadow = lv; m_st = 0; m_alarm = 0; end
            else if (sp) begin m_st = 0; m_alarm = 0; end
            else if (tk && m_alarm) begin
               m_acnt++;
               if (m_acnt == ALEN) m_alarm = 0;
            end
      endcase
   endtask

   task automatic cmp_model();
      chk("count", 32'(dut_cnt()), 32'(to_bcd(m_secs)));
      chk("running", 32'(bus.running), 32'(m_st == 1));
      chk("done", 32'(bus.done), 32'(m_st == 3 || m_pulse));
      chk("alarm", 32'(bus.alarm), 32'(m_alarm));
   endtask

   // Apply one cycle of inputs from a posedge; DUT samples on the negedge; compare at next posedge.
   task automatic drive(input bit ld, input bit st, input bit sp, input bit tk,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
      bus.load = ld; bus.start = st; bus.stop = sp; bus.tick = tk;
      bus.ld_min_t = a; bus.ld_min_u = b; bus.ld_sec_t = c; bus.ld_sec_u = d;
      m_step(ld, st, sp, tk, ld_secs(int'(a), int'(b), int'(c), int'(d)));
      @(posedge clk);
      cmp_model();
   endtask

   initial begin
      clear = 1'b0;
      bus.load = 0; bus.start = 0; bus.stop = 0; bus.tick = 0;
      bus.ld_min_t = 0; bus.ld_min_u = 0; bus.ld_sec_t = 0; bus.ld_sec_u = 0;
      m_reset();
      repeat (2) @(posedge clk);
      cmp_model();
      clear = 1'b1;

      // async clear mid-run
      drive(1, 0, 0, 0, 4'd1, 4'd2, 4'd3, 4'd4);
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      chk("run_1234", {15'd0, bus.running, dut_cnt()}, 32'h1_1234);
      #2 clear = 1'b0;
      #1;
      chk("clr_cnt", 32'(dut_cnt()), 32'h0);
      chk("clr_flags", {29'd0, bus.running, bus.done, bus.alarm}, 32'h0);
      m_reset();
      @(posedge clk);
      clear = 1'b1;

`ifdef COUNTDOWN_AUTORELOAD_EN
      drive(1, 0, 0, 0, 0, 0, 0, 4'd2);
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0, 0, 0);
      chk("reload", {14'd0, bus.running, bus.done, dut_cnt()}, 32'h3_0002);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk("pulse_end", 32'(bus.done), 32'h0);
      drive(0, 0, 1, 0, 0, 0, 0, 0);
      chk("stop_pause", 32'(bus.running), 32'h0);
      drive(1, 0, 0, 0, 0, 0, 0, 0);
`else
      // expiry and alarm
      drive(1, 0, 0, 0, 0, 0, 0, 4'd3);
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0, 0, 0);
      chk("tick1", 32'(dut_cnt()), 32'h0002);
      drive(0, 0, 0, 1, 0, 0, 0, 0);
      chk("tick2", 32'(dut_cnt()), 32'h0001);
      drive(0, 0, 0, 1, 0, 0, 0, 0);
      chk("expire", {13'd0, bus.running, bus.done, bus.alarm, dut_cnt()}, 32'h3_0000);
      for (int i = 1; i <= ALEN; i++) begin
         drive(0, 0, 0, 1, 0, 0, 0, 0);
         chk("alarm_len", 32'(bus.alarm), 32'(i < ALEN));
      end
      drive(0, 0, 1, 0, 0, 0, 0, 0);
      chk("ack_idle", {30'd0, bus.done, bus.running}, 32'h0);
`endif

      // full borrow chain
      drive(1, 0, 0, 0, 4'd1, 4'd0, 4'd0, 4'd0);
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      chk("start_nodec", 32'(dut_cnt()), 32'h1000);
      drive(0, 0, 0, 1, 0, 0, 0, 0);
      chk("borrow", 32'(dut_cnt()), 32'h0959);

      // stop beats tick, load ignored in run, start resumes
      drive(0, 1, 1, 1, 0, 0, 0, 0);
      chk("stop_tick", {15'd0, bus.running, dut_cnt()}, 32'h0_0959);
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 1, 4'd5, 4'd5, 4'd5, 4'd5);
      chk("ld_in_run", {15'd0, bus.running, dut_cnt()}, 32'h1_0958);
      drive(0, 0, 1, 0, 0, 0, 0, 0);

      // clamping, then zero start ignored
      drive(1, 0, 0, 0, 4'hF, 4'hC, 4'h7, 4'hA);
      chk("clamp", 32'(dut_cnt()), 32'h9959);
      drive(0, 0, 1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      chk("zero_start", 32'(bus.running), 32'h0);

      for (int n = 0; n < 3000; n++) begin
         bit ld, st, sp, tk;
         logic [3:0] a, b, c, d;
         ld = ($urandom_range(0, 15) == 0);
         st = ($urandom_range(0, 3) == 0);
         sp = ($urandom_range(0, 19) == 0);
         tk = ($urandom_range(0, 1) == 0);
         if ($urandom_range(0, 1) == 0) begin
            a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15));
            c = 4'($urandom_range(0, 15)); d = 4'($urandom_range(0, 15));
         end else begin
            a = 0; b = 0; c = 0; d = 4'($urandom_range(1, 5));
         end
         drive(ld, st, sp, tk, a, b, c, d);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
